// File: rtl/wavetable_nco_mc.sv
// Multi-channel wavetable NCO: per-channel phase accumulators sharing one
// simple dual-port sample table, framed by a strobe divider and read sequencer.

module wavetable_nco_ch #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               sync,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [ADDR_W-1:0]  poff,
  output logic [ADDR_W-1:0]  addr
);
  logic [PHASE_W-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (sync) acc <= '0;
    else if (tick) acc <= acc + fcw;
  end

  assign addr = acc[PHASE_W-1 -: ADDR_W] + poff;
endmodule

module wavetable_nco_mc #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 12,
  parameter int PHASE_W = 24,
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we_i,
  input  logic [ADDR_W-1:0]         cfg_addr_i,
  input  logic [DATA_W-1:0]         cfg_data_i,
  input  logic                      enable_i,
  input  logic                      sync_i,
  input  logic [DIV_W-1:0]          div_i,
  input  logic [NUM_CH*PHASE_W-1:0] fcw_i,
  input  logic [NUM_CH*ADDR_W-1:0]  poff_i,
  output logic [NUM_CH*DATA_W-1:0]  data_o,
  output logic                      valid_o
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(NUM_CH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, COMMIT} state_t;

  state_t                           state, state_nx;
  logic [CH_W-1:0]                  ch, ch_nx;
  logic [DIV_W-1:0]                 cnt, div_eff;
  logic                             tick;
  logic [NUM_CH-1:0][ADDR_W-1:0]    ch_addr;
  logic [ADDR_W-1:0]                rd_addr;
  logic [DATA_W-1:0]                rd_q;
  logic [DATA_W-1:0]                mem [DEPTH];
  logic [NUM_CH-1:0][DATA_W-1:0]    shadow, frame, data_q;
  logic                             cap_vld;
  logic [CH_W-1:0]                  cap_ch;

  // Floor on the period keeps every tick landing in IDLE or COMMIT.
  assign div_eff = (div_i < DIV_MIN) ? DIV_MIN : div_i;
  assign tick    = enable_i & ~sync_i & (cnt >= div_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (sync_i || !enable_i) cnt <= '0;
    else if (tick)                cnt <= '0;
    else                          cnt <= cnt + DIV_W'(1);
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      wavetable_nco_ch #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .sync  (sync_i),
        .fcw   (fcw_i[k*PHASE_W +: PHASE_W]),
        .poff  (poff_i[k*ADDR_W +: ADDR_W]),
        .addr  (ch_addr[k])
      );
    end
  endgenerate

  assign rd_addr = ch_addr[ch];

  // Read-before-write: a same-address write returns the old sample.
  always_ff @(posedge clk) begin
    if (cfg_we_i) mem[cfg_addr_i] <= cfg_data_i;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    unique case (state)
      IDLE:   if (tick) begin
                state_nx = READ;
                ch_nx    = '0;
              end
      READ:   if (ch == CH_W'(NUM_CH - 1)) state_nx = DRAIN;
              else                         ch_nx    = ch + CH_W'(1);
      DRAIN:  state_nx = COMMIT;
      COMMIT: if (tick) begin
                state_nx = READ;
                ch_nx    = '0;
              end else begin
                state_nx = IDLE;
              end
      default: state_nx = IDLE;
    endcase
    if (sync_i) begin
      state_nx = IDLE;
      ch_nx    = '0;
    end
  end

  // Sample for the channel issued last cycle is on rd_q now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld <= 1'b0;
      cap_ch  <= '0;
    end else begin
      cap_vld <= (state == READ) & ~sync_i;
      cap_ch  <= ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       shadow <= '0;
    else if (cap_vld) shadow[cap_ch] <= rd_q;
  end

  always_comb begin
    frame = shadow;
    if (cap_vld) frame[cap_ch] = rd_q;
  end

  // Committing at the DRAIN edge makes data_o and valid_o appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          data_q <= '0;
    else if (state == DRAIN && !sync_i)  data_q <= frame;
  end

  assign data_o  = data_q;
  assign valid_o = (state == COMMIT);
endmodule

// File: tb/tb_wavetable_nco_mc.sv
// Randomized and directed bench for wavetable_nco_mc against a frame-schedule model.

module tb_wavetable_nco_mc;
  localparam int DATA_W = 8, ADDR_W = 12, PHASE_W = 24, NUM_CH = 2, DIV_W = 16;
  localparam int DEPTH = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic enable = 1'b0, sync = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [NUM_CH*PHASE_W-1:0] fcw = '0;
  logic [NUM_CH*ADDR_W-1:0] poff = '0;
  logic [NUM_CH*DATA_W-1:0] data_o;
  logic valid_o;

  always #5 clk = ~clk;

  wavetable_nco_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W),
                     .NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .enable_i(enable), .sync_i(sync), .div_i(div),
    .fcw_i(fcw), .poff_i(poff), .data_o(data_o), .valid_o(valid_o)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a tick at cycle T schedules reads of ch k in cycle T+1+k and a
  // commit visible in cycle T+NUM_CH+2.
  logic [DATA_W-1:0] tbl [DEPTH];
  int unsigned m_acc [NUM_CH];
  int m_cnt, m_start, m_cyc;
  bit m_active, m_valid;
  logic [DATA_W-1:0] m_sh [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] m_data;

  function automatic int div_eff_f();
    return (int'(div) < NUM_CH + 1) ? NUM_CH + 1 : int'(div);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NUM_CH; j++) m_acc[j] = 0;
    m_cnt = 0; m_active = 0; m_valid = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit vnext;
    int k, a;
    vnext = 0;
    k = m_cyc - m_start - 1;
    if (m_active && k >= 0 && k < NUM_CH) begin
      a = (int'(m_acc[k] >> (PHASE_W - ADDR_W)) + int'(poff[k*ADDR_W +: ADDR_W])) % DEPTH;
      m_sh[k] = tbl[a];
    end
    if (m_active && m_cyc == m_start + NUM_CH + 1 && !sync) begin
      for (int j = 0; j < NUM_CH; j++) m_data[j*DATA_W +: DATA_W] = m_sh[j];
      vnext = 1; m_active = 0;
    end
    if (cfg_we) tbl[cfg_addr] = cfg_data;
    if (sync) begin
      for (int j = 0; j < NUM_CH; j++) m_acc[j] = 0;
      m_cnt = 0; m_active = 0;
    end else if (enable && m_cnt >= div_eff_f()) begin
      for (int j = 0; j < NUM_CH; j++)
        m_acc[j] = (m_acc[j] + int'(fcw[j*PHASE_W +: PHASE_W])) & 32'h00FF_FFFF;
      m_active = 1; m_start = m_cyc; m_cnt = 0;
    end else if (enable) m_cnt++;
    else m_cnt = 0;
    m_valid = vnext;
    m_cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    model_step();
    chk("valid", {31'b0, valid_o}, {31'b0, m_valid});
    chk("data", 32'(data_o), 32'(m_data));
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin cycle(); n++; end while (!valid_o && n < max);
    if (!valid_o) chk("timeout_valid", 0, 1);
  endtask

  // which: 0 = first READ cycle, 1 = DRAIN cycle of the current frame
  task automatic wait_phase(input int which, input int max);
    int n, off;
    off = (which == 0) ? 1 : NUM_CH + 1;
    n = 0;
    while (!(m_active && m_cyc == m_start + off) && n < max) begin cycle(); n++; end
    if (!(m_active && m_cyc == m_start + off)) chk("timeout_phase", 0, 1);
  endtask

  task automatic pulse_sync();
    sync = 1'b1; cycle(); sync = 1'b0;
  endtask

  initial begin
    int n;
    logic [NUM_CH*DATA_W-1:0] held;
    m_cyc = 0; m_start = -100;
    #2 rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    chk("rst_valid", {31'b0, valid_o}, 0);
    chk("rst_data", 32'(data_o), 0);
    rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) begin
      cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_data = DATA_W'(a);
      cycle();
    end
    cfg_we = 1'b0;

    // basic
    fcw[0 +: PHASE_W] = 24'h001000; fcw[PHASE_W +: PHASE_W] = 24'h010000;
    div = 16'd9; enable = 1'b1;
    wait_valid(40, n);
    chk("basic_ch0_1", 32'(data_o[7:0]), 1);
    chk("basic_ch1_1", 32'(data_o[15:8]), 16);
    wait_valid(40, n);
    chk("basic_period", n, 10);
    chk("basic_ch0_2", 32'(data_o[7:0]), 2);
    chk("basic_ch1_2", 32'(data_o[15:8]), 32);
    repeat (40) cycle();

    // wrap
    fcw[0 +: PHASE_W] = 24'hFFF000;
    pulse_sync();
    wait_valid(40, n);
    chk("wrap_1", 32'(data_o[7:0]), 32'hFF);
    wait_valid(40, n);
    chk("wrap_2", 32'(data_o[7:0]), 32'hFE);
    repeat (30) cycle();

    // offset
    fcw[0 +: PHASE_W] = 24'h001000; fcw[PHASE_W +: PHASE_W] = 24'h001000;
    poff[ADDR_W +: ADDR_W] = 12'h805;
    pulse_sync();
    wait_valid(40, n);
    chk("offset_ch0", 32'(data_o[7:0]), 1);
    chk("offset_ch1", 32'(data_o[15:8]), 6);
    repeat (30) cycle();
    poff = '0;

    // clamp
    div = '0;
    wait_valid(40, n);
    wait_valid(40, n);
    chk("clamp_period_a", n, 4);
    wait_valid(40, n);
    chk("clamp_period_b", n, 4);
    div = 16'd40;
    repeat (20) cycle();
    div = 16'd3;
    wait_valid(40, n);
    chk("clamp_lower_lat", n, 4);
    wait_valid(40, n);
    chk("clamp_lower_next", n, 4);

    // sync during READ
    div = 16'd9;
    wait_valid(40, n);
    wait_phase(0, 40);
    held = data_o;
    sync = 1'b1; cycle(); sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("sync_hold", 32'(data_o), 32'(held));
      chk("sync_novalid", {31'b0, valid_o}, 0);
    end
    wait_valid(40, n);
    chk("sync_next_ch0", 32'(data_o[7:0]), 1);

    // async reset in DRAIN
    wait_phase(1, 40);
    rst_n = 1'b0;
    #1;
    chk("rst_drain_valid", {31'b0, valid_o}, 0);
    chk("rst_drain_data", 32'(data_o), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_cyc++;
    repeat (5) cycle();

    // table write during issue of the same address
    fcw = '0; poff[0 +: ADDR_W] = 12'd5;
    pulse_sync();
    wait_phase(0, 40);
    cfg_we = 1'b1; cfg_addr = 12'd5; cfg_data = 8'hA5;
    cycle();
    cfg_we = 1'b0;
    wait_valid(40, n);
    chk("rw_old", 32'(data_o[7:0]), 32'h05);
    wait_valid(40, n);
    chk("rw_new", 32'(data_o[7:0]), 32'hA5);

    // random
    for (int i = 0; i < 3000; i++) begin
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = ADDR_W'($urandom); cfg_data = DATA_W'($urandom);
      sync = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 49) == 0) div = DIV_W'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) begin
        fcw = {PHASE_W'($urandom), PHASE_W'($urandom)};
        poff = {ADDR_W'($urandom), ADDR_W'($urandom)};
      end
      cycle();
    end
    sync = 1'b0; cfg_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
